i2s_clock_sequencer: RTL and testbench

Master-mode timing generator and frame sequencer for the I2S receive path. It derives bclk and lrclk from the system clock using a runtime-programmable divider and tracks bit position within each slot. It emits one-cycle strobes that tell the downstream I2S capture and PWM stages when a left or right 24-bit sample is complete. Start and stop are frame-aligned, so downstream logic never sees a partial frame.

---
 rtl/i2s_pkg.sv | 44 ++++
 rtl/i2s_bclk_divider.sv | 76 +++++++
 rtl/i2s_clock_sequencer.sv | 178 +++++++++++++++++
 tb/tb_i2s_clock_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_pkg
//  Purpose  : Shared definitions for the I2S clock sequencer: default sample
//             and slot sizes, FSM state encoding, configuration limits and
//             the configuration legality check.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package i2s_pkg;

  // Default sample width and maximum slot length (in bclk periods).
  localparam int unsigned DATA_BITS_DEF = 24;
  localparam int unsigned MAX_SLOT_DEF  = 32;

  // Divider limits: a half-period of zero clk cycles cannot be generated.
  localparam int unsigned HALF_DIV_MIN = 1;
  localparam int unsigned HALF_DIV_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // A slot must be long enough to hold the one-bit delay plus all data bits,
  // and short enough for the bit counter.
  function automatic logic cfg_legal(
    input logic [7:0]  half_div,
    input logic [5:0]  slot_bits,
    input int unsigned data_bits,
    input int unsigned max_slot
  );
    logic ok_h;
    logic ok_s;
    ok_h = (32'(half_div) >= HALF_DIV_MIN) && (32'(half_div) <= HALF_DIV_MAX);
    ok_s = (32'(slot_bits) > data_bits) && (32'(slot_bits) <= max_slot);
    return ok_h && ok_s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_bclk_divider
//  Purpose  : Half-period counter generating a 50% duty bclk of period
//             2*half_div_i clk cycles while run_i is high. When run_i is low
//             the counter and bclk are held at 0.
//  Ports    : clk            system clock
//             reset_n        asynchronous active-low reset
//             run_i          enable counting/toggling
//             half_div_i     clk cycles per bclk half-period (frozen value)
//             rise_next_o    comb: bclk rises at the coming clk edge
//             fall_next_o    comb: bclk falls at the coming clk edge
//             bclk_o         registered bit clock
//             rise_o         registered one-cycle pulse with bclk 0->1
//  Revision : 1.0  initial release
// ============================================================================
module i2s_bclk_divider (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_i,
  input  logic [7:0] half_div_i,
  output logic       rise_next_o,
  output logic       fall_next_o,
  output logic       bclk_o,
  output logic       rise_o
);

  logic [7:0] half_cnt_q;
  logic [7:0] half_cnt_d;
  logic       bclk_q;
  logic       bclk_d;
  logic       rise_q;
  logic       rise_d;
  logic       w_tick;

  // Last clk cycle of the current half-period.
  assign w_tick      = run_i && (half_cnt_q == (half_div_i - 8'd1));
  // The edge decode is exposed ahead of the register so the sequencer can
  // move lrclk and the bit counter on the very same clk edge as bclk.
  assign rise_next_o = w_tick && !bclk_q;
  assign fall_next_o = w_tick && bclk_q;

  always_comb begin
    half_cnt_d = half_cnt_q;
    bclk_d     = bclk_q;
    rise_d     = 1'b0;
    if (!run_i) begin
      half_cnt_d = 8'd0;
      bclk_d     = 1'b0;
    end else if (w_tick) begin
      half_cnt_d = 8'd0;
      bclk_d     = ~bclk_q;
      rise_d     = ~bclk_q;
    end else begin
      half_cnt_d = half_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt_q <= 8'd0;
      bclk_q     <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      bclk_q     <= bclk_d;
      rise_q     <= rise_d;
    end
  end

  assign bclk_o = bclk_q;
  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/i2s_clock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_clock_sequencer
//  Purpose  : Master-mode I2S timing generator. Produces bclk/lrclk from clk
//             with a programmable divider, tracks the bit index in each slot
//             and emits one-cycle strobes when a left/right sample is
//             complete. Starts and stops are aligned to whole frames.
//  Ports    : clk             system clock
//             reset_n         asynchronous active-low reset
//             enable          level: 1 = run, 0 = stop at end of frame
//             cfg_half_div    clk cycles per bclk half-period (1..255)
//             cfg_slot_bits   bclk periods per slot (DATA_BITS+1..MAX_SLOT)
//             bclk            bit clock
//             lrclk           word clock (0 = left, 1 = right)
//             bclk_rise       pulse with bclk 0->1
//             frame_start     pulse with lrclk 1->0
//             l_sample_valid  pulse when a left sample is complete
//             r_sample_valid  pulse when a right sample is complete
//             running         high in START, RUN and STOP
//             cfg_err         sticky illegal-configuration flag
//  Revision : 1.0  initial release
// ============================================================================
module i2s_clock_sequencer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned MAX_SLOT  = MAX_SLOT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] cfg_half_div,
  input  logic [5:0] cfg_slot_bits,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_rise,
  output logic       frame_start,
  output logic       l_sample_valid,
  output logic       r_sample_valid,
  output logic       running,
  output logic       cfg_err
);

  localparam int unsigned CNT_W = $clog2(MAX_SLOT + 1);
  // The strobe fires on the bclk fall that ends the LSB bit period.
  localparam logic [CNT_W-1:0] STROBE_IDX = CNT_W'(DATA_BITS);

  state_e           state_q;
  logic [7:0]       half_div_q;
  logic [5:0]       slot_bits_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             lrclk_q;
  logic             frame_start_q;
  logic             l_valid_q;
  logic             r_valid_q;
  logic             running_q;
  logic             cfg_err_q;

  logic             w_run;
  logic             w_rise_next;
  logic             w_fall_next;
  logic [CNT_W-1:0] w_last_idx;
  logic             w_slot_end;
  logic             w_cfg_ok;

  assign w_run      = (state_q != ST_IDLE);
  assign w_last_idx = CNT_W'(slot_bits_q) - CNT_W'(1);
  assign w_slot_end = (bit_cnt_q == w_last_idx);
  assign w_cfg_ok   = cfg_legal(cfg_half_div, cfg_slot_bits, DATA_BITS, MAX_SLOT);

  i2s_bclk_divider u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .run_i       (w_run),
    .half_div_i  (half_div_q),
    .rise_next_o (w_rise_next),
    .fall_next_o (w_fall_next),
    .bclk_o      (bclk),
    .rise_o      (bclk_rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      half_div_q    <= 8'd0;
      slot_bits_q   <= 6'd0;
      bit_cnt_q     <= '0;
      lrclk_q       <= 1'b1;
      frame_start_q <= 1'b0;
      l_valid_q     <= 1'b0;
      r_valid_q     <= 1'b0;
      running_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      l_valid_q     <= 1'b0;
      r_valid_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          lrclk_q   <= 1'b1;
          bit_cnt_q <= '0;
          if (!enable) begin
            cfg_err_q <= 1'b0;
          end else if (!cfg_err_q) begin
            // Shadow copies stay frozen until the next start.
            half_div_q  <= cfg_half_div;
            slot_bits_q <= cfg_slot_bits;
            if (!w_cfg_ok) begin
              cfg_err_q <= 1'b1;
            end else begin
              // bclk is already low, so this is treated as the frame
              // boundary: the left slot (index 0, the delay bit) begins
              // now and its first rising edge ends START.
              state_q       <= ST_START;
              running_q     <= 1'b1;
              lrclk_q       <= 1'b0;
              frame_start_q <= 1'b1;
            end
          end
        end

        ST_START: begin
          if (w_rise_next) begin
            state_q <= ST_RUN;
          end
        end

        ST_RUN, ST_STOP: begin
          if (state_q == ST_RUN && !enable) begin
            state_q <= ST_STOP;
          end else if (state_q == ST_STOP && enable) begin
            state_q <= ST_RUN;
          end

          if (w_fall_next) begin
            // With the minimum slot length this strobe shares the edge with
            // the lrclk toggle; the pre-toggle lrclk still names the side.
            if (bit_cnt_q == STROBE_IDX) begin
              l_valid_q <= ~lrclk_q;
              r_valid_q <= lrclk_q;
            end

            if (w_slot_end) begin
              bit_cnt_q <= '0;
              if (state_q == ST_STOP && !enable && lrclk_q) begin
                // End of the right slot while stopping: hold lrclk high so
                // no new frame (and no frame_start) begins.
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
                lrclk_q   <= 1'b1;
              end else begin
                lrclk_q       <= ~lrclk_q;
                frame_start_q <= lrclk_q;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lrclk          = lrclk_q;
  assign frame_start    = frame_start_q;
  assign l_sample_valid = l_valid_q;
  assign r_sample_valid = r_valid_q;
  assign running        = running_q;
  assign cfg_err        = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_clock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_clock_sequencer
//  Purpose  : Directed self-checking bench for i2s_clock_sequencer. Expected
//             pulse times are queued per pulse type when stimulus is applied
//             and compared when the DUT emits the pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2s_clock_sequencer;

  localparam int DB = 24;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] cfg_half_div;
  logic [5:0] cfg_slot_bits;
  logic       bclk;
  logic       lrclk;
  logic       bclk_rise;
  logic       frame_start;
  logic       l_sample_valid;
  logic       r_sample_valid;
  logic       running;
  logic       cfg_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int rise_cnt = 0;
  int lr_tog   = 0;
  logic prev_bclk = 1'b0;
  logic prev_lr   = 1'b1;

  int q_fs[$];
  int q_l[$];
  int q_r[$];

  i2s_clock_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .cfg_half_div   (cfg_half_div),
    .cfg_slot_bits  (cfg_slot_bits),
    .bclk           (bclk),
    .lrclk          (lrclk),
    .bclk_rise      (bclk_rise),
    .frame_start    (frame_start),
    .l_sample_valid (l_sample_valid),
    .r_sample_valid (r_sample_valid),
    .running        (running),
    .cfg_err        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One frame starting at 'base': left strobe 25 bclk falls after the
  // frame start, right strobe 25 falls after the right slot begins.
  task automatic push_frame(input int base, input int h, input int s);
    q_fs.push_back(base);
    q_l.push_back(base + 2 * h * (DB + 1));
    q_r.push_back(base + 2 * h * (s + DB + 1));
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_fs_pending"}, q_fs.size(), 0);
    check({tag, "_l_pending"},  q_l.size(),  0);
    check({tag, "_r_pending"},  q_r.size(),  0);
  endtask

  // Scoreboard pop side: every pulse must match the oldest queued time.
  always @(negedge clk) begin
    int e;
    if (bclk_rise) begin
      rise_cnt++;
      check("bclk_rise_edge", int'({prev_bclk, bclk}), 1);
    end
    if (lrclk !== prev_lr) lr_tog++;
    if (frame_start) begin
      e = (q_fs.size() > 0) ? q_fs.pop_front() : -1;
      check("frame_start_time", cyc, e);
    end
    if (l_sample_valid) begin
      e = (q_l.size() > 0) ? q_l.pop_front() : -1;
      check("l_valid_time", cyc, e);
    end
    if (r_sample_valid) begin
      e = (q_r.size() > 0) ? q_r.pop_front() : -1;
      check("r_valid_time", cyc, e);
    end
    prev_bclk = bclk;
    prev_lr   = lrclk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int r0;
    int t0;

    reset_n       = 1'b0;
    enable        = 1'b0;
    cfg_half_div  = 8'd2;
    cfg_slot_bits = 6'd32;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_bclk",    int'(bclk), 0);
    check("rst_lrclk",   int'(lrclk), 1);
    check("rst_running", int'(running), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_pulses",  int'({bclk_rise, frame_start, l_sample_valid, r_sample_valid}), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_running", int'(running), 0);

    // Test 1: H=2, S=32, three frames then a stop requested mid-left-slot
    @(negedge clk);
    enable = 1'b1;
    b  = cyc + 1;
    r0 = rise_cnt;
    t0 = lr_tog;
    push_frame(b, 2, 32);
    push_frame(b + 256, 2, 32);
    push_frame(b + 512, 2, 32);
    wait_until(b);
    check("t1_running",   int'(running), 1);
    check("t1_cfg_err",   int'(cfg_err), 0);
    check("t1_lrclk_l",   int'(lrclk), 0);
    check("t1_start_low", int'(bclk), 0);
    wait_until(b + 2);
    check("t1_first_rise", int'(bclk), 1);
    wait_until(b + 4);
    check("t1_first_fall", int'(bclk), 0);
    wait_until(b + 562);
    enable = 1'b0;
    wait_until(b + 767);
    check("t1_stop_run_before", int'(running), 1);
    wait_until(b + 768);
    check("t1_stop_running", int'(running), 0);
    check("t1_stop_bclk",    int'(bclk), 0);
    check("t1_stop_lrclk",   int'(lrclk), 1);
    wait_until(b + 800);
    check("t1_rise_count",   rise_cnt - r0, 192);
    check("t1_lrclk_toggles", lr_tog - t0, 6);
    check_queues_empty("t1");

    // Test 4: brief enable dip inside STOP resumes without a gap
    @(negedge clk);
    enable = 1'b1;
    b  = cyc + 1;
    r0 = rise_cnt;
    t0 = lr_tog;
    push_frame(b, 2, 32);
    push_frame(b + 256, 2, 32);
    wait_until(b + 200);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_until(b + 306);
    enable = 1'b0;
    wait_until(b + 511);
    check("t4_run_before", int'(running), 1);
    wait_until(b + 512);
    check("t4_stop_running", int'(running), 0);
    check("t4_stop_lrclk",   int'(lrclk), 1);
    wait_until(b + 530);
    check("t4_rise_count",    rise_cnt - r0, 128);
    check("t4_lrclk_toggles", lr_tog - t0, 4);
    check_queues_empty("t4");

    // Test 2: illegal configurations
    @(negedge clk);
    cfg_half_div  = 8'd0;
    cfg_slot_bits = 6'd32;
    enable        = 1'b1;
    r0 = rise_cnt;
    @(negedge clk);
    check("t2_h0_cfg_err", int'(cfg_err), 1);
    check("t2_h0_running", int'(running), 0);
    repeat (20) @(negedge clk);
    check("t2_h0_bclk",     int'(bclk), 0);
    check("t2_h0_no_rise",  rise_cnt - r0, 0);
    check("t2_h0_sticky",   int'(cfg_err), 1);
    enable = 1'b0;
    @(negedge clk);
    check("t2_h0_clear", int'(cfg_err), 0);
    cfg_half_div  = 8'd2;
    cfg_slot_bits = 6'd24;
    enable        = 1'b1;
    @(negedge clk);
    check("t2_s24_cfg_err", int'(cfg_err), 1);
    check("t2_s24_running", int'(running), 0);
    enable = 1'b0;
    @(negedge clk);
    check("t2_s24_clear", int'(cfg_err), 0);
    cfg_slot_bits = 6'd33;
    enable        = 1'b1;
    @(negedge clk);
    check("t2_s33_cfg_err", int'(cfg_err), 1);
    enable = 1'b0;
    @(negedge clk);
    check("t2_s33_clear", int'(cfg_err), 0);

    // Test 5: H=1, S=25 -- 100-cycle frames
    @(negedge clk);
    cfg_half_div  = 8'd1;
    cfg_slot_bits = 6'd25;
    enable        = 1'b1;
    b  = cyc + 1;
    r0 = rise_cnt;
    push_frame(b, 1, 25);
    push_frame(b + 100, 1, 25);
    wait_until(b + 1);
    check("t5_bclk_c1", int'(bclk), 1);
    wait_until(b + 2);
    check("t5_bclk_c2", int'(bclk), 0);
    wait_until(b + 3);
    check("t5_bclk_c3", int'(bclk), 1);
    wait_until(b + 120);
    enable = 1'b0;
    wait_until(b + 199);
    check("t5_run_before", int'(running), 1);
    wait_until(b + 200);
    check("t5_stop_running", int'(running), 0);
    check("t5_stop_lrclk",   int'(lrclk), 1);
    wait_until(b + 220);
    check("t5_rise_count", rise_cnt - r0, 100);
    check_queues_empty("t5");

    // Test 6: asynchronous reset mid-frame
    @(negedge clk);
    cfg_half_div  = 8'd2;
    cfg_slot_bits = 6'd32;
    enable        = 1'b1;
    b = cyc + 1;
    q_fs.push_back(b);
    wait_until(b + 60);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_bclk",    int'(bclk), 0);
    check("t6_async_lrclk",   int'(lrclk), 1);
    check("t6_async_running", int'(running), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_idle_running", int'(running), 0);
    check("t6_idle_bclk",    int'(bclk), 0);
    check("t6_idle_lrclk",   int'(lrclk), 1);
    check_queues_empty("t6a");
    @(negedge clk);
    enable = 1'b1;
    b = cyc + 1;
    push_frame(b, 2, 32);
    wait_until(b + 60);
    enable = 1'b0;
    wait_until(b + 256);
    check("t6_stop_running", int'(running), 0);
    wait_until(b + 270);
    check_queues_empty("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
